// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for a multicycle MIPS datapath. Each instruction is
// sequenced through fetch, decode, execute, memory and writeback steps. Every
// datapath strobe and mux select is a Moore decode of the current state.
//
// Memory handshake: mem_ready=1 means the memory completes the current access
// in this cycle. FETCH, MEMRD and MEMWR hold their state, with their request
// strobes still asserted, until mem_ready is seen high. The state advances at
// the clock edge where mem_ready=1.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   opcode         in   IR[31:26]; stable from DECODE until the next FETCH
//   mem_ready      in   memory completes the current access this cycle
//   pc_write       out  unconditional PC load
//   pc_write_cond  out  conditional PC load (branch)
//   branch_ne      out  1 = take branch on zero=0 (bne), 0 = on zero=1 (beq)
//   i_or_d         out  memory address select: 0 = PC, 1 = ALUOut
//   mem_read       out  memory read request
//   mem_write      out  memory write request
//   ir_write       out  IR load
//   mem_to_reg     out  writeback select: 1 = MDR, 0 = ALUOut
//   reg_dst        out  destination: 1 = rd, 0 = rt
//   reg_write      out  register file write
//   alu_src_a      out  ALU A: 0 = PC, 1 = rs
//   alu_src_b      out  ALU B: 00 = rt, 01 = 4, 10 = imm, 11 = imm << 2
//   ALUOp          out  00 = add, 01 = subtract, 10 = use funct
//   pc_source      out  PC mux: 00 = ALU result, 01 = ALUOut, 10 = jump
//   state          out  current state code (debug)
//   illegal_op     out  unknown opcode seen in DECODE (that cycle only)
//   instr_count    out  retired-instruction counter, wraps
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         ALUOp,
  output logic [1:0]         pc_source,
  output logic [3:0]         state,
  output logic               illegal_op,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] instr_count_q, instr_count_d;
  logic               illegal_dec;
  logic               retire;

  // ---------------------------------------------------------------------------
  // State and counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    illegal_dec = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXECUTE;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:       state_d = S_ADDIEX;
          OP_J:          state_d = S_JUMP;
          default: begin
            // Unknown opcode: drop the instruction and refetch.
            state_d     = S_FETCH;
            illegal_dec = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      // Codes 12-15 are unreachable in normal operation; recover to FETCH.
      default:   state_d = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter. An instruction retires on the transition
  // into FETCH from a completing state; the DECODE -> FETCH path taken on an
  // illegal opcode is deliberately excluded.
  // ---------------------------------------------------------------------------
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEMWR:                                      retire = mem_ready;
      default:                                      retire = 1'b0;
    endcase
  end

  always_comb begin
    instr_count_d = instr_count_q;
    if (retire) instr_count_d = instr_count_q + COUNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Moore output decode. Anything not set for a state stays 0. While reset is
  // high, the strobes are masked and the mux selects show their FETCH values
  // regardless of the state, so a reset mid-instruction can never issue a
  // write.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    ALUOp         = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;

    if (reset) begin
      alu_src_b = SRCB_FOUR;
    end else begin
      illegal_op = illegal_dec;
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          // IR and PC+4 are captured on the cycle the fetch completes.
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          // Speculatively compute the branch target into ALUOut.
          alu_src_b = SRCB_IMM4;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          ALUOp     = ALU_FUNCT;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          ALUOp         = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          branch_ne     = (opcode == OP_BNE);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
        default: begin
        end
      endcase
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control, instantiated with COUNT_W=4 so the
// counter wrap can be reached with 16 jumps. Inputs change 1 time unit after
// the rising edge and the outputs are sampled 2 units later, well away from
// both clock edges.
//
// Expected output vectors below are written out by hand from the state
// output table. Bit order:
//   {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write,
//    ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
//    alu_src_b[1:0], ALUOp[1:0], pc_source[1:0]}
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  localparam int CW = 4;

  //                                   pw pc bn io mr mw ir m2 rd rw a  srcb aop psrc
  localparam logic [16:0] V_RESET  = 17'b0_0_0_0_0_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] V_FETCHR = 17'b1_0_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [16:0] V_FETCHW = 17'b0_0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] V_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] V_ADR    = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [16:0] V_MEMRD  = 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_MEMWR  = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [16:0] V_MEMWB  = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [16:0] V_EXEC   = 17'b0_0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [16:0] V_ALUWB  = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [16:0] V_ADDIWB = 17'b0_0_0_0_0_0_0_0_0_1_0_00_00_00;
  localparam logic [16:0] V_BNE    = 17'b0_1_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] V_BEQ    = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [16:0] V_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;

  // clock / reset / DUT signals
  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, branch_ne, i_or_d;
  logic          mem_read, mem_write, ir_write, mem_to_reg;
  logic          reg_dst, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, ALUOp, pc_source;
  logic [3:0]    state;
  logic          illegal_op;
  logic [CW-1:0] instr_count;
  logic [16:0]   outs;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ALUOp(ALUOp), .pc_source(pc_source), .state(state),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  assign outs = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read,
                 mem_write, ir_write, mem_to_reg, reg_dst, reg_write,
                 alu_src_a, alu_src_b, ALUOp, pc_source};

  // driver / checker tasks
  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check state and output vector in the current cycle, then advance one edge.
  task automatic cyc(input string tag, input logic [3:0] exp_state,
                     input logic [16:0] exp_outs);
    #2;
    chk({tag, ".state"}, 32'(state), 32'(exp_state));
    chk({tag, ".outs"}, 32'(outs), 32'(exp_outs));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
    #2;
    chk(tag, 32'(instr_count), 32'(exp));
  endtask

  task automatic chk_ill(input string tag, input logic exp);
    #2;
    chk(tag, 32'(illegal_op), 32'(exp));
  endtask

  // Run one j instruction starting in FETCH with mem_ready=1.
  task automatic run_jump(input string tag);
    opcode    = 6'b000010;
    mem_ready = 1'b1;
    cyc({tag, ".f"}, 4'd0,  V_FETCHR);
    cyc({tag, ".d"}, 4'd1,  V_DECODE);
    cyc({tag, ".j"}, 4'd11, V_JUMP);
  endtask

  initial begin
    // reset held for two edges
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    @(posedge clk);
    #1;
    chk_cnt("rst.count", 4'd0);
    chk_ill("rst.illegal", 1'b0);
    cyc("rst.c1", 4'd0, V_RESET);
    cyc("rst.c2", 4'd0, V_RESET);
    reset = 1'b0;

    // R-type: 0,1,6,7,0
    cyc("r.fetch",   4'd0, V_FETCHR);
    cyc("r.decode",  4'd1, V_DECODE);
    cyc("r.execute", 4'd6, V_EXEC);
    cyc("r.aluwb",   4'd7, V_ALUWB);
    chk_cnt("r.count", 4'd1);

    // lw with 3 wait cycles in MEMRD: 0,1,2,3,3,3,3,4,0
    opcode = 6'b100011;
    cyc("lw.fetch",  4'd0, V_FETCHR);
    cyc("lw.decode", 4'd1, V_DECODE);
    cyc("lw.memadr", 4'd2, V_ADR);
    mem_ready = 1'b0;
    cyc("lw.wait1",  4'd3, V_MEMRD);
    cyc("lw.wait2",  4'd3, V_MEMRD);
    cyc("lw.wait3",  4'd3, V_MEMRD);
    mem_ready = 1'b1;
    cyc("lw.memrd",  4'd3, V_MEMRD);
    cyc("lw.memwb",  4'd4, V_MEMWB);
    chk_cnt("lw.count", 4'd2);

    // bne then beq: 0,1,8,0
    opcode = 6'b000101;
    cyc("bne.fetch",  4'd0, V_FETCHR);
    cyc("bne.decode", 4'd1, V_DECODE);
    cyc("bne.branch", 4'd8, V_BNE);
    chk_cnt("bne.count", 4'd3);
    opcode = 6'b000100;
    cyc("beq.fetch",  4'd0, V_FETCHR);
    cyc("beq.decode", 4'd1, V_DECODE);
    cyc("beq.branch", 4'd8, V_BEQ);
    chk_cnt("beq.count", 4'd4);

    // illegal opcode: flag only in DECODE, back to FETCH, no count
    opcode = 6'b111111;
    chk_ill("ill.fetch_flag", 1'b0);
    cyc("ill.fetch",  4'd0, V_FETCHR);
    chk_ill("ill.decode_flag", 1'b1);
    cyc("ill.decode", 4'd1, V_DECODE);
    chk_ill("ill.after_flag", 1'b0);
    chk_cnt("ill.count", 4'd4);

    // jump
    run_jump("j");
    chk_cnt("j.count", 4'd5);

    // FETCH wait: hold with mem_read up, no ir_write/pc_write
    opcode    = 6'b001000;
    mem_ready = 1'b0;
    cyc("addi.fwait", 4'd0, V_FETCHW);
    mem_ready = 1'b1;
    cyc("addi.fetch",  4'd0,  V_FETCHR);
    cyc("addi.decode", 4'd1,  V_DECODE);
    cyc("addi.ex",     4'd9,  V_ADR);
    cyc("addi.wb",     4'd10, V_ADDIWB);
    chk_cnt("addi.count", 4'd6);

    // sw completing normally: 0,1,2,5,0
    opcode = 6'b101011;
    cyc("sw.fetch",  4'd0, V_FETCHR);
    cyc("sw.decode", 4'd1, V_DECODE);
    cyc("sw.memadr", 4'd2, V_ADR);
    cyc("sw.memwr",  4'd5, V_MEMWR);
    chk_cnt("sw.count", 4'd7);

    // sw abandoned by reset while waiting in MEMWR
    cyc("swr.fetch",  4'd0, V_FETCHR);
    cyc("swr.decode", 4'd1, V_DECODE);
    cyc("swr.memadr", 4'd2, V_ADR);
    mem_ready = 1'b0;
    cyc("swr.wait",   4'd5, V_MEMWR);
    reset = 1'b1;
    cyc("swr.reset",  4'd5, V_RESET);
    chk_cnt("swr.count_rst", 4'd0);
    reset     = 1'b0;
    mem_ready = 1'b1;
    chk_cnt("swr.count_after", 4'd0);

    // 16 retirements wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) begin
      run_jump("wrap");
      if (i == 14) chk_cnt("wrap.count15", 4'd15);
    end
    chk_cnt("wrap.count0", 4'd0);
    cyc("wrap.end", 4'd0, V_FETCHR);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #20000;
    total++;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
